// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder/subtractor. A single full-adder cell is reused for WIDTH
// consecutive clock cycles, LSB first, to add (a + b + cin) or subtract
// (a - b - cin) two WIDTH-bit operands. Subtraction is performed as
// a + ~b + ~cin, so in sub mode cout = 1 means "no borrow".
//
// A start/busy/done handshake frames each operation:
//   - start is accepted in IDLE or DONE. It is ignored while an operation
//     is running.
//   - busy is high for the WIDTH cycles of RUN.
//   - done pulses for one cycle (the DONE state), when sum/cout/ovf update.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset (priority over start)
//   start  request a new operation
//   a, b   operands, captured on an accepted start
//   cin    carry-in (add) / borrow-in (sub), captured on an accepted start
//   sub    0 = add, 1 = subtract, captured on an accepted start
//   sum    result of the last completed operation
//   cout   carry out of the MSB cell
//   ovf    two's-complement overflow of the last completed operation
//   busy   operation in progress
//   done   one-cycle completion pulse
// ---------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Full-adder cell: sum and majority carry.
  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Operand shift registers: the bit under processing is always at index 0.
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;

  // Partial result: holds bits 0..cnt-1, filled MSB-in / shift-right so that
  // together with the final sum bit it forms the complete result.
  logic [WIDTH-2:0] res_sr;

  logic             accept;
  logic             running;
  logic             last;
  logic             s_bit;
  logic             c_nxt;
  logic [WIDTH-1:0] res_nxt;

  always_comb begin
    accept  = start && ((state == IDLE) || (state == DONE));
    running = (state == RUN);
    last    = running && (cnt == LAST_BIT);
    s_bit   = fa_sum(op_a[0], op_b[0], carry);
    c_nxt   = fa_carry(op_a[0], op_b[0], carry);
    res_nxt = {s_bit, res_sr};
  end

  // Datapath: operand capture and per-bit shifting. Not reset: the contents
  // are meaningless outside RUN and are always reloaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub ? ~cin : cin;
    end else if (running) begin
      op_a   <= op_a >> 1;
      op_b   <= op_b >> 1;
      carry  <= c_nxt;
      res_sr <= res_nxt[WIDTH-1:1];
    end
  end

  // Control FSM and registered result/flag outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (last) begin
            // Counter is left at WIDTH-1 rather than wrapping; it is
            // cleared on the next accept.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= res_nxt;
            cout  <= c_nxt;
            // Overflow: carry into the MSB cell differs from carry out.
            ovf   <= carry ^ c_nxt;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Directed bench for serial_adder. A WIDTH=8 instance covers the arithmetic
// cases, the handshake and mid-operation reset; a WIDTH=2 instance is swept
// over every combination of a, b, cin and sub against a signed/unsigned
// integer reference.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8, sub8;
  logic [7:0] sum8;
  logic       cout8, ovf8, busy8, done8;

  logic       start2;
  logic [1:0] a2, b2;
  logic       cin2, sub2;
  logic [1:0] sum2;
  logic       cout2, ovf2, busy2, done2;

  int tests = 0;
  int fails = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .sub(sub8), .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8),
    .done(done8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .sub(sub2), .sum(sum2), .cout(cout2), .ovf(ovf2), .busy(busy2),
    .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for done on the 8-bit instance. Edge numbering continues from k0;
  // lat is the edge index at which done was seen (-1 on timeout), bcnt the
  // number of busy-high cycles observed while waiting.
  task automatic wait8(input int k0, output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int k = k0 + 1; (k <= k0 + 24) && (lat < 0); k++) begin
      if (busy8) bcnt++;
      step();
      if (done8) lat = k;
    end
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input logic ts, output int lat, output int bcnt);
    a8 = ta; b8 = tb; cin8 = tc; sub8 = ts;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    wait8(0, lat, bcnt);
  endtask

  task automatic res8(input string tag, input int lat, input logic [7:0] es,
                      input logic ec, input logic eo);
    chk({tag, "_lat"},  lat,   8);
    chk({tag, "_sum"},  sum8,  es);
    chk({tag, "_cout"}, cout8, ec);
    chk({tag, "_ovf"},  ovf8,  eo);
    chk({tag, "_busy"}, busy8, 1'b0);
  endtask

  initial begin
    int lat, lat2, bcnt, dcnt;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_sum8",  sum8,  8'h00);
    chk("rst_cout8", cout8, 1'b0);
    chk("rst_ovf8",  ovf8,  1'b0);
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_done8", done8, 1'b0);
    chk("rst_sum2",  sum2,  2'b00);
    chk("rst_busy2", busy2, 1'b0);
    rst = 1'b0;
    step();

    // Basic add with busy-length check
    run8(8'h0F, 8'h01, 1'b0, 1'b0, lat, bcnt);
    res8("add0f01", lat, 8'h10, 1'b0, 1'b0);
    chk("add0f01_busycycles", bcnt, 8);
    step();
    chk("add0f01_done_one_cycle", done8, 1'b0);
    chk("add0f01_hold_sum", sum8, 8'h10);

    // Carry / overflow cases
    run8(8'hFF, 8'h01, 1'b0, 1'b0, lat, bcnt);
    res8("addff01", lat, 8'h00, 1'b1, 1'b0);
    run8(8'h7F, 8'h01, 1'b0, 1'b0, lat, bcnt);
    res8("add7f01", lat, 8'h80, 1'b0, 1'b1);
    run8(8'h80, 8'h80, 1'b1, 1'b0, lat, bcnt);
    res8("add8080c", lat, 8'h01, 1'b1, 1'b1);

    // Subtraction
    run8(8'h05, 8'h07, 1'b0, 1'b1, lat, bcnt);
    res8("sub0507", lat, 8'hFE, 1'b0, 1'b0);
    run8(8'h80, 8'h01, 1'b0, 1'b1, lat, bcnt);
    res8("sub8001", lat, 8'h7F, 1'b1, 1'b1);

    // Start pulsed during RUN (bit 3) with different operands is ignored
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    step();
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; sub8 = 1'b1;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    wait8(4, lat, bcnt);
    res8("ignore_start", lat, 8'h10, 1'b0, 1'b0);

    // Back-to-back: start held high through the DONE cycle
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0;
    start8 = 1'b1;
    step();
    wait8(0, lat, bcnt);
    res8("b2b_first", lat, 8'h46, 1'b0, 1'b0);
    a8 = 8'h80; b8 = 8'h81;
    step();
    chk("b2b_busy_after_done", busy8, 1'b1);
    chk("b2b_done_low", done8, 1'b0);
    start8 = 1'b0;
    wait8(9, lat2, bcnt);
    chk("b2b_second_edge", lat2, 17);
    chk("b2b_second_sum", sum8, 8'h01);
    chk("b2b_second_cout", cout8, 1'b1);
    chk("b2b_second_ovf", ovf8, 1'b1);

    // Reset at RUN bit 4 aborts the operation
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_sum",  sum8,  8'h00);
    chk("midrst_cout", cout8, 1'b0);
    chk("midrst_ovf",  ovf8,  1'b0);
    chk("midrst_busy", busy8, 1'b0);
    chk("midrst_done", done8, 1'b0);
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done8 || busy8) dcnt++;
    end
    chk("midrst_no_done", dcnt, 0);
    run8(8'h12, 8'h34, 1'b0, 1'b0, lat, bcnt);
    res8("after_rst", lat, 8'h46, 1'b0, 1'b0);

    // Exhaustive WIDTH=2 against an integer reference
    for (int ai = 0; ai < 4; ai++) begin
      for (int bi = 0; bi < 4; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          for (int si = 0; si < 2; si++) begin
            int va, vb, r, u, l2;
            logic [1:0] es;
            logic ec, eo;
            string tg;
            va = (ai > 1) ? ai - 4 : ai;
            vb = (bi > 1) ? bi - 4 : bi;
            r  = (si != 0) ? va - vb - ci : va + vb + ci;
            u  = (si != 0) ? ai - bi - ci : ai + bi + ci;
            es = 2'(u & 3);
            ec = (si != 0) ? (u >= 0) : (u >= 4);
            eo = (r < -2) || (r > 1);
            a2 = 2'(ai); b2 = 2'(bi); cin2 = ci[0]; sub2 = si[0];
            start2 = 1'b1;
            step();
            start2 = 1'b0;
            l2 = -1;
            for (int k = 1; (k <= 8) && (l2 < 0); k++) begin
              step();
              if (done2) l2 = k;
            end
            tg = $sformatf("w2_a%0d_b%0d_c%0d_s%0d", ai, bi, ci, si);
            chk({tg, "_lat"},  l2,    2);
            chk({tg, "_sum"},  sum2,  es);
            chk({tg, "_cout"}, cout2, ec);
            chk({tg, "_ovf"},  ovf2,  eo);
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
